// File: rtl/uart_word_rx.sv
// uart_word_rx: UART receive front end that assembles 8N1 (or 8+parity) bytes
// MSB-first into WORD_BYTES-wide words and presents them on a valid/ready
// stream with a wrapping in-frame word index.
// Optional feature macro: UART_RX_TIMEOUT_EN. When defined, a partial word is
// discarded after TIMEOUT_BITS idle bit times.
module uart_word_rx #(
    parameter int CLK_FREQ     = 200_000_000,
    parameter int BAUD         = 115200,
    parameter int WORD_BYTES   = 2,
    parameter int FRAME_WORDS  = 96,
    parameter int PARITY       = 0,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                           sys_clk,
    input  logic                           rst,
    input  logic                           uart_rx,
    input  logic                           err_clr,
    output logic [8*WORD_BYTES-1:0]        word_data,
    output logic [$clog2(FRAME_WORDS)-1:0] word_idx,
    output logic                           frame_last,
    output logic                           word_valid,
    input  logic                           word_ready,
    output logic                           err_frame,
    output logic                           err_parity,
    output logic                           err_overrun
);

    localparam int DIV    = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int HALF   = DIV / 2;
    localparam int CNT_W  = $clog2(DIV) + 1;
    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int IDX_W  = $clog2(FRAME_WORDS);
    localparam int BCNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    // Expected parity bit for a data byte: mode 1 = odd, otherwise even.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        logic p;
        if (mode == 1) begin
            p = ~(^data);
        end else begin
            p = ^data;
        end
        return p;
    endfunction

    // Synchroniser and edge detector
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic rx_prev_q, rx_prev_d;
    logic rx_s;
    logic rx_fall;

    // Receive FSM
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bitn_q, bitn_d;
    logic [7:0]        rxbyte_q, rxbyte_d;
    logic              tick;
    logic              good_byte;
    logic              drop_byte;
    logic              perr_new;
    logic              ferr_new;

    // Word assembly
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              word_done;
    logic              timeout_hit;

    // Output register and sticky flags
    logic [WORD_W-1:0] word_data_q, word_data_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [IDX_W-1:0]  next_idx_q, next_idx_d;
    logic              frame_last_q, frame_last_d;
    logic              word_valid_q, word_valid_d;
    logic              err_frame_q, err_frame_d;
    logic              err_parity_q, err_parity_d;
    logic              err_overrun_q, err_overrun_d;
    logic              ovr_new;

    assign rx_s    = sync2_q;
    assign rx_fall = rx_prev_q & ~sync2_q;
    assign tick    = (cnt_q == {CNT_W{1'b0}});

    // Next values of the line synchroniser (preset high so reset is not a start bit)
    always_comb begin
        sync1_d   = uart_rx;
        sync2_d   = sync1_q;
        rx_prev_d = sync2_q;
    end

    // Receive FSM: next state, bit timing counter and byte deserialiser
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitn_d    = bitn_q;
        rxbyte_d  = rxbyte_q;
        good_byte = 1'b0;
        drop_byte = 1'b0;
        perr_new  = 1'b0;
        ferr_new  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_fall) begin
                    state_d = S_START;
                    cnt_d   = CNT_W'(HALF - 1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rx_s) begin
                        // Line went back high before mid-bit: treat as noise.
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = CNT_W'(DIV - 1);
                        bitn_d  = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (tick) begin
                    rxbyte_d = {rx_s, rxbyte_q[7:1]};
                    cnt_d    = CNT_W'(DIV - 1);
                    if (bitn_q == 3'd7) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                        end else begin
                            state_d = S_STOP;
                        end
                    end else begin
                        bitn_d = bitn_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (tick) begin
                    cnt_d = CNT_W'(DIV - 1);
                    if (rx_s != parity_bit(rxbyte_q, PARITY)) begin
                        // Bad byte: skip its stop bit and resync on the next idle.
                        perr_new  = 1'b1;
                        drop_byte = 1'b1;
                        state_d   = S_WAIT_IDLE;
                    end else begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        good_byte = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        ferr_new  = 1'b1;
                        drop_byte = 1'b1;
                        state_d   = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_BITS * DIV;
    logic [31:0] idle_cnt_q, idle_cnt_d;

    // Inter-byte gap counter: only runs while a partial word is waiting
    always_comb begin
        timeout_hit = 1'b0;
        idle_cnt_d  = idle_cnt_q;
        if ((state_q == S_IDLE) && (bcnt_q != {BCNT_W{1'b0}})) begin
            if (idle_cnt_q == 32'(TO_LIMIT - 1)) begin
                timeout_hit = 1'b1;
                idle_cnt_d  = 32'd0;
            end else begin
                idle_cnt_d = idle_cnt_q + 32'd1;
            end
        end else begin
            idle_cnt_d = 32'd0;
        end
    end

    // Idle counter register
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            idle_cnt_q <= 32'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    // Without the timeout a partial word waits indefinitely
    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    // Word assembly: shift good bytes in, drop partial words on a bad byte or timeout
    always_comb begin
        shreg_d   = shreg_q;
        bcnt_d    = bcnt_q;
        word_done = 1'b0;
        if (good_byte) begin
            shreg_d = (shreg_q << 8) | WORD_W'(rxbyte_q);
            if (bcnt_q == BCNT_W'(WORD_BYTES - 1)) begin
                word_done = 1'b1;
                bcnt_d    = {BCNT_W{1'b0}};
            end else begin
                bcnt_d = bcnt_q + BCNT_W'(1);
            end
        end else if (drop_byte || timeout_hit) begin
            bcnt_d = {BCNT_W{1'b0}};
        end else begin
            bcnt_d = bcnt_q;
        end
    end

    // Single-entry output register, word index and sticky error flags
    always_comb begin
        word_data_d  = word_data_q;
        word_idx_d   = word_idx_q;
        next_idx_d   = next_idx_q;
        frame_last_d = frame_last_q;
        word_valid_d = word_valid_q;
        ovr_new      = word_done & word_valid_q & ~word_ready;
        if (word_done && (!word_valid_q || word_ready)) begin
            word_valid_d = 1'b1;
            word_data_d  = shreg_d;
            word_idx_d   = next_idx_q;
            frame_last_d = (next_idx_q == IDX_W'(FRAME_WORDS - 1));
            if (next_idx_q == IDX_W'(FRAME_WORDS - 1)) begin
                next_idx_d = {IDX_W{1'b0}};
            end else begin
                next_idx_d = next_idx_q + IDX_W'(1);
            end
        end else if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end else begin
            word_valid_d = word_valid_q;
        end
        // A new error wins over a coincident clear.
        err_frame_d   = (err_frame_q & ~err_clr) | ferr_new;
        err_parity_d  = (err_parity_q & ~err_clr) | perr_new;
        err_overrun_d = (err_overrun_q & ~err_clr) | ovr_new;
    end

    // State register for the whole block
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            bitn_q        <= 3'd0;
            rxbyte_q      <= 8'h00;
            shreg_q       <= {WORD_W{1'b0}};
            bcnt_q        <= {BCNT_W{1'b0}};
            word_data_q   <= {WORD_W{1'b0}};
            word_idx_q    <= {IDX_W{1'b0}};
            next_idx_q    <= {IDX_W{1'b0}};
            frame_last_q  <= 1'b0;
            word_valid_q  <= 1'b0;
            err_frame_q   <= 1'b0;
            err_parity_q  <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            rx_prev_q     <= rx_prev_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bitn_q        <= bitn_d;
            rxbyte_q      <= rxbyte_d;
            shreg_q       <= shreg_d;
            bcnt_q        <= bcnt_d;
            word_data_q   <= word_data_d;
            word_idx_q    <= word_idx_d;
            next_idx_q    <= next_idx_d;
            frame_last_q  <= frame_last_d;
            word_valid_q  <= word_valid_d;
            err_frame_q   <= err_frame_d;
            err_parity_q  <= err_parity_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign word_data   = word_data_q;
    assign word_idx    = word_idx_q;
    assign frame_last  = frame_last_q;
    assign word_valid  = word_valid_q;
    assign err_frame   = err_frame_q;
    assign err_parity  = err_parity_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// Testbench for uart_word_rx. The bit rate is scaled so one bit is 16 clocks
// (CLK_FREQ 1.6 MHz, BAUD 100 kbit/s); a word-level model predicts every
// handshake, and directed checks pin literal results.
module tb_uart_word_rx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int WB       = 2;
    localparam int FW       = 96;
    localparam int TOB      = 20;
    localparam int BIT_CYC  = 16;   // (1_600_000 + 50_000) / 100_000

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        err_clr = 1'b0;
    logic        word_ready = 1'b1;
    logic [15:0] word_data;
    logic [6:0]  word_idx;
    logic        frame_last;
    logic        word_valid;
    logic        err_frame;
    logic        err_parity;
    logic        err_overrun;

    always #5 clk = ~clk;

    uart_word_rx #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .WORD_BYTES(WB),
        .FRAME_WORDS(FW), .PARITY(0), .TIMEOUT_BITS(TOB)
    ) dut (
        .sys_clk(clk), .rst(rst), .uart_rx(uart_rx), .err_clr(err_clr),
        .word_data(word_data), .word_idx(word_idx), .frame_last(frame_last),
        .word_valid(word_valid), .word_ready(word_ready),
        .err_frame(err_frame), .err_parity(err_parity), .err_overrun(err_overrun)
    );

    typedef struct {
        logic [15:0] data;
        int          idx;
        logic        last;
    } exp_t;

    exp_t        pend[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          hs_count = 0;
    int          last_seen = 0;
    logic [15:0] last_flag_data = 16'h0000;
    logic [15:0] last_hs_data = 16'h0000;
    int          last_hs_idx = 0;
    logic        hold_q = 1'b0;
    logic [15:0] held_data = 16'h0000;

    // word-level model state
    logic [15:0] part = 16'h0000;
    int          m_bcnt = 0;
    int          m_idx = 0;
    logic        exp_ferr = 1'b0;
    logic        exp_ovr = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare process: every handshake against the model, stability while stalled
    always @(negedge clk) begin
        if (rst) begin
            hold_q = 1'b0;
        end else begin
            check("parity_flag_zero", err_parity, 0);
            if (hold_q) begin
                check("hold_valid", word_valid, 1);
                check("hold_data", word_data, held_data);
            end
            if (word_valid && word_ready) begin
                n_tests++;
                if (pend.size() == 0) begin
                    n_fail++;
                    $display("FAIL hs_unexpected: word %h idx %0d with nothing expected", word_data, word_idx);
                end else begin
                    exp_t e;
                    e = pend.pop_front();
                    check("hs_data", word_data, e.data);
                    check("hs_idx", word_idx, e.idx);
                    check("hs_last", frame_last, e.last);
                end
                hs_count++;
                last_hs_data = word_data;
                last_hs_idx  = word_idx;
                if (frame_last) begin
                    last_seen++;
                    last_flag_data = word_data;
                end
            end
            hold_q    = word_valid && !word_ready;
            held_data = word_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_good(input logic [7:0] b);
        exp_t e;
        part = {part[7:0], b};
        m_bcnt++;
        if (m_bcnt == WB) begin
            m_bcnt = 0;
            if (pend.size() != 0 && !word_ready) begin
                exp_ovr = 1'b1;
            end else begin
                e.data = part;
                e.idx  = m_idx;
                e.last = (m_idx == FW - 1);
                pend.push_back(e);
                m_idx = (m_idx + 1) % FW;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        uart_rx = 1'b0;
        tick(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(BIT_CYC);
        end
        // model learns the byte just before the stop bit is sampled
        if (stop_ok) begin
            model_good(b);
        end else begin
            m_bcnt   = 0;
            exp_ferr = 1'b1;
        end
        uart_rx = stop_ok;
        tick(BIT_CYC);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    task automatic idle_bits(input int n);
        uart_rx = 1'b1;
        tick(n * BIT_CYC);
`ifdef UART_RX_TIMEOUT_EN
        if (n > TOB) begin
            m_bcnt = 0;
        end
`endif
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_err_frame"}, err_frame, exp_ferr);
        check({tag, "_err_overrun"}, err_overrun, exp_ovr);
        check({tag, "_err_parity"}, err_parity, 0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr  = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        tick(1);
        check_flags("after_clr");
    endtask

    task automatic do_reset();
        uart_rx    = 1'b1;
        word_ready = 1'b1;
        err_clr    = 1'b0;
        rst        = 1'b1;
        pend.delete();
        part     = 16'h0000;
        m_bcnt   = 0;
        m_idx    = 0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        tick(2);
        check("rst_valid", word_valid, 0);
        check("rst_data", word_data, 0);
        check("rst_idx", word_idx, 0);
        check("rst_last", frame_last, 0);
        check_flags("rst");
        rst = 1'b0;
        tick(2);
    endtask

    // Watchdog so the run always ends
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        tick(1);

        // basic word
        do_reset();
        send_word(16'h1234);
        idle_bits(2);
        check("t1_drain", pend.size(), 0);
        check("t1_data", last_hs_data, 16'h1234);
        check("t1_idx", last_hs_idx, 0);
        check("t1_count", hs_count, 1);
        check_flags("t1");

        // reset in the middle of a word and of a byte loses the partial data
        send_byte(8'h99, 1'b1);
        uart_rx = 1'b0;
        tick(4 * BIT_CYC);
        do_reset();
        base = hs_count;
        send_word(16'hABCD);
        idle_bits(2);
        check("rstmid_count", hs_count - base, 1);
        check("rstmid_data", last_hs_data, 16'hABCD);
        check("rstmid_idx", last_hs_idx, 0);

        // full frame plus one: index wraps, frame_last only on the final word
        do_reset();
        base      = hs_count;
        last_seen = 0;
        for (int i = 0; i < FW; i++) begin
            send_word(16'(i));
        end
        send_word(16'h0060);
        idle_bits(2);
        check("frame_count", hs_count - base, 97);
        check("frame_last_seen", last_seen, 1);
        check("frame_last_data", last_flag_data, 16'h005F);
        check("frame_wrap_idx", last_hs_idx, 0);
        check("frame_wrap_data", last_hs_data, 16'h0060);
        check("frame_drain", pend.size(), 0);

        // framing error drops the byte, next word is clean
        do_reset();
        send_byte(8'hA5, 1'b0);
        idle_bits(2);
        send_word(16'h5678);
        idle_bits(2);
        check("ferr_flag", err_frame, 1);
        check("ferr_data", last_hs_data, 16'h5678);
        check("ferr_idx", last_hs_idx, 0);
        check_flags("ferr");
        pulse_clr();

        // overrun: second word dropped while the first is stalled
        word_ready = 1'b0;
        send_word(16'hAAAA);
        send_word(16'hBBBB);
        idle_bits(2);
        check("ovr_valid", word_valid, 1);
        check("ovr_data", word_data, 16'hAAAA);
        check("ovr_flag", err_overrun, 1);
        check_flags("ovr");
        base       = hs_count;
        word_ready = 1'b1;
        tick(4);
        check("ovr_accept_count", hs_count - base, 1);
        check("ovr_accept_data", last_hs_data, 16'hAAAA);
        check("ovr_accept_idx", last_hs_idx, 1);
        check("ovr_valid_low", word_valid, 0);
        check("ovr_drain", pend.size(), 0);
        pulse_clr();

        // short low glitch is not a start bit
        base    = hs_count;
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(2 * BIT_CYC);
        check("glitch_no_word", hs_count - base, 0);
        check_flags("glitch");
        send_word(16'h0F0F);
        idle_bits(2);
        check("glitch_next_data", last_hs_data, 16'h0F0F);
        check("glitch_next_idx", last_hs_idx, 2);
        check("glitch_drain", pend.size(), 0);

        // long gap inside a word
        do_reset();
        base = hs_count;
        send_byte(8'h11, 1'b1);
        idle_bits(25);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        idle_bits(2);
        check("gap_count", hs_count - base, 1);
`ifdef UART_RX_TIMEOUT_EN
        check("gap_data", last_hs_data, 16'h2233);
`else
        check("gap_data", last_hs_data, 16'h1122);
`endif
        check("gap_drain", pend.size(), 0);
        check_flags("gap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Parametrised UART receive front end for the accelerator input path. It deserialises 8N1 (optionally 8-bit + parity) bytes from the host, assembles them MSB-first into WORD_BYTES-wide words, and presents each word on a valid/ready stream. Each word carries its index within a FRAME_WORDS-long input frame. The block sits directly behind the `uart_rx` pad in `sys_top` and feeds the input-buffer writer.

## Interface
- CLK_FREQ, 200_000_000 — sys_clk frequency in Hz
- BAUD, 115200 — line rate in bit/s
- WORD_BYTES, 2 — bytes per output word (1..4)
- FRAME_WORDS, 96 — words per frame; word index wraps after this count
- PARITY, 0 — 0 none, 1 odd, 2 even
- TIMEOUT_BITS, 20 — inter-byte gap, in bit times, that discards a partial word (only with UART_RX_TIMEOUT_EN)

- sys_clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- uart_rx  in  1  asynchronous serial line, idle high
- err_clr  in  1  single-cycle pulse clears all sticky error flags
- word_data  out  8*WORD_BYTES  assembled word, first byte received in the MSBs
- word_idx  out  $clog2(FRAME_WORDS)  position of word_data in the frame
- frame_last  out  1  high with the word where word_idx == FRAME_WORDS-1
- word_valid  out  1  word_data/word_idx/frame_last are valid
- word_ready  in  1  consumer accepts when word_valid && word_ready
- err_frame  out  1  sticky: stop bit sampled low
- err_parity  out  1  sticky: parity mismatch (stuck at 0 when PARITY=0)
- err_overrun  out  1  sticky: a word was dropped because the output register was full

## Operation
- uart_rx passes through a 2-FF synchroniser preset to 1 by rst. All decisions use the synchronised value.
- Bit clock: DIV = (CLK_FREQ + BAUD/2) / BAUD and HALF = DIV/2. With the defaults, DIV = 1736.
- Receive FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE -> START on a synchronised falling edge. The counter loads HALF.
  - START: at mid-bit, if rx = 1 the start was a glitch; go to IDLE with no error. Otherwise go to DATA with the counter at DIV.
  - DATA: sample 8 bits LSB-first at each mid-bit. Then go to PARITY (PARITY != 0) or to STOP.
  - PARITY: sample 1 bit. A mismatch sets err_parity and the byte is discarded.
  - STOP: rx = 1 means the byte is good; go to IDLE. rx = 0 sets err_frame, discards the byte, and goes to WAIT_IDLE.
  - WAIT_IDLE: go to IDLE once rx = 1. This handles a break condition.
- Word assembly:
  - Each good byte shifts in: shreg <= {shreg[8*WORD_BYTES-9:0], byte}.
  - A byte counter counts 0..WORD_BYTES-1. When the last byte arrives, the word is complete.
  - A discarded byte (parity or framing error) also resets the byte counter, so the partial word is dropped.
- Output register (single entry):
  - A complete word loads the register if it is empty, or if it is being accepted in the same cycle.
  - If word_valid && !word_ready, the new word is dropped and err_overrun is set. word_idx does not advance.
  - word_idx increments on each loaded word. It wraps from FRAME_WORDS-1 to 0.
- Error flags are sticky. They clear on rst or err_clr. If err_clr and a new error coincide, the flag stays set.

## Timing
- Reset values:
  - word_valid = 0, word_data = 0, word_idx = 0, frame_last = 0.
  - All error flags = 0. FSM = IDLE. Byte counter = 0.
- Start-bit detection lags the pin by 2-3 cycles because of the synchroniser.
- word_valid rises on the cycle after the STOP mid-bit sample of the last byte of a word.
- word_valid stays high, with data stable, until the cycle after the handshake. No combinational path from word_ready to any output.
- Back-to-back accept: valid can remain high continuously when a new word loads in the handshake cycle.
- rst mid-byte or mid-word: everything returns to reset values on the next edge. The partial byte/word is lost.

## Configuration
- UART_RX_TIMEOUT_EN defined:
  - An idle counter runs while the byte counter is nonzero and the FSM is in IDLE.
  - After TIMEOUT_BITS*DIV cycles it clears the byte counter, discarding the partial word. No error flag is set.
- UART_RX_TIMEOUT_EN undefined: no counter. A partial word waits indefinitely for its remaining bytes.

## Test plan
- Reset, then send bytes 0x12, 0x34 at 115200 with DIV = 1736 and word_ready = 1 -> one word_valid pulse with word_data = 0x1234, word_idx = 0, frame_last = 0, no errors.
- Send 96 words 0x0000..0x005F back-to-back -> 96 handshakes; word_idx = 0..95; frame_last only on 0x005F. Then one more word -> word_idx = 0.
- Send a byte with the stop bit low, then 0x56, 0x78 -> err_frame = 1, first byte dropped, next word = 0x5678. err_clr -> err_frame = 0.
- Hold word_ready = 0 and send two words 0xAAAA, 0xBBBB -> word_data stays 0xAAAA, err_overrun = 1. Raise ready -> only 0xAAAA is accepted, word_idx = 1.
- 200 ns low glitch on uart_rx -> no byte, no error flag, FSM back in IDLE.
- With UART_RX_TIMEOUT_EN: send 0x11, idle for 25 bit times, then send 0x22, 0x33 -> output word = 0x2233. Without the macro, the same stimulus gives output word = 0x1122.
